// File: rtl/fetch_sequencer.sv
// Per-core fetch/dispatch sequencer: memory read, MIDR latch + PC increment, IR write,
// then dispatch to execute with halt detection, stop latch, watchdog and retire counter.
module fetch_sequencer #(
    parameter logic [3:0] HALT_OPCODE  = 4'b1111,
    parameter int         IR_WR_BIT    = 19,
    parameter int         EXEC_TIMEOUT = 64,
    parameter int         CNT_W        = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_req_i,
    input  logic [3:0]       ir_opcode_i,
    input  logic             exec_done_i,
    output logic [1:0]       mem_ctrl_o,
    output logic             pcd_o,
    output logic [19:0]      wrdec_out_o,
    output logic             exec_start_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic [2:0]       state_out_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_RD   = 3'd1,
        S_MIDR_LD  = 3'd2,
        S_IR_LD    = 3'd3,
        S_DISPATCH = 3'd4,
        S_EXEC     = 3'd5,
        S_HALTED   = 3'd6,
        S_ILLEGAL  = 3'd7
    } state_t;

    // Watchdog counts 0..EXEC_TIMEOUT-1; the last value is the timeout cycle.
    localparam int              WD_W    = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
    localparam bit              WD_EN   = (EXEC_TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((EXEC_TIMEOUT > 0) ? EXEC_TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic               stop_q, stop_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fault_q, fault_d;
    logic [1:0]         mem_ctrl_q;
    logic               pcd_q;
    logic               wr_q;
    logic               dispatch_q;
    logic               busy_q;
    logic               halted_q;

    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        wd_d    = wd_q;
        count_d = count_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_req_i) begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD:  state_d = S_MIDR_LD;
            S_MIDR_LD: state_d = S_IR_LD;
            S_IR_LD:   state_d = S_DISPATCH;
            S_DISPATCH: begin
                if (ir_opcode_i == HALT_OPCODE) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_EXEC;
                    wd_d    = '0;
                end
            end
            S_EXEC: begin
                // A completion in the timeout cycle takes priority over the fault.
                if (exec_done_i) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = stop_q ? S_IDLE : S_MEM_RD;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    state_d = S_HALTED;
                    fault_d = 1'b1;
                end else if (WD_EN) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        if (busy_q && stop_req_i) begin
            stop_d = 1'b1;
        end
        if (state_d == S_IDLE) begin
            stop_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            stop_q     <= 1'b0;
            wd_q       <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            mem_ctrl_q <= 2'b00;
            pcd_q      <= 1'b0;
            wr_q       <= 1'b0;
            dispatch_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_q     <= stop_d;
            wd_q       <= wd_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
            mem_ctrl_q <= (state_d == S_MEM_RD) ? 2'b01 : 2'b00;
            pcd_q      <= (state_d == S_MIDR_LD);
            wr_q       <= (state_d == S_IR_LD);
            dispatch_q <= (state_d == S_DISPATCH);
            busy_q     <= (state_d inside {S_MEM_RD, S_MIDR_LD, S_IR_LD, S_DISPATCH, S_EXEC});
            halted_q   <= (state_d == S_HALTED);
        end
    end

    // The opcode is only known once IR has been written, so the halt check gates the strobe.
    assign exec_start_o  = dispatch_q && (ir_opcode_i != HALT_OPCODE);
    assign mem_ctrl_o    = mem_ctrl_q;
    assign pcd_o         = pcd_q;
    assign busy_o        = busy_q;
    assign halted_o      = halted_q;
    assign fault_o       = fault_q;
    assign instr_count_o = count_q;
    assign state_out_o   = state_q;

    for (genvar gi = 0; gi < 20; gi++) begin : g_wrdec
        assign wrdec_out_o[gi] = (gi == IR_WR_BIT) ? wr_q : 1'b0;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a fixed vector table, directed corner sequences and a
// randomized run against a cycle-level reference model of the fetch/execute rules.
module tb_fetch_sequencer;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop_req = 1'b0;
    logic          done = 1'b0;
    logic [3:0]    op = 4'h0;
    logic [1:0]    mem_ctrl;
    logic          pcd;
    logic [19:0]   wrdec;
    logic          exec_start;
    logic          busy;
    logic          halted;
    logic          fault;
    logic [CW-1:0] cnt;
    logic [2:0]    state_out;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_sequencer #(
        .HALT_OPCODE (4'b1111),
        .IR_WR_BIT   (19),
        .EXEC_TIMEOUT(TO),
        .CNT_W       (CW)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .start_i      (start),
        .stop_req_i   (stop_req),
        .ir_opcode_i  (op),
        .exec_done_i  (done),
        .mem_ctrl_o   (mem_ctrl),
        .pcd_o        (pcd),
        .wrdec_out_o  (wrdec),
        .exec_start_o (exec_start),
        .busy_o       (busy),
        .halted_o     (halted),
        .fault_o      (fault),
        .instr_count_o(cnt),
        .state_out_o  (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: running flag, position within the instruction (1..4 fetch/dispatch,
    // 5 executing), cycles spent executing, stop request, halt/fault, retired count.
    bit m_run, m_halt, m_fault, m_stop;
    int m_pos, m_wait, m_cnt;

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_fault = 0; m_stop = 0;
        m_pos = 0; m_wait = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit old_stop;
        if (m_halt) return;
        if (!m_run) begin
            if (start && !stop_req) begin
                m_run = 1;
                m_pos = 1;
            end
            return;
        end
        old_stop = m_stop;
        if (stop_req) m_stop = 1;
        if (m_pos < 4) begin
            m_pos++;
        end else if (m_pos == 4) begin
            if (op == 4'hF) begin
                m_halt = 1; m_run = 0;
            end else begin
                m_pos = 5; m_wait = 0;
            end
        end else if (done) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            if (old_stop) begin
                m_run = 0; m_stop = 0;
            end else begin
                m_pos = 1;
            end
        end else begin
            m_wait++;
            if (m_wait == TO) begin
                m_halt = 1; m_run = 0; m_fault = 1;
            end
        end
    endtask

    task automatic check_model();
        int es;
        es = m_halt ? 6 : (m_run ? m_pos : 0);
        chk("state", state_out, es);
        chk("mem_ctrl", mem_ctrl, (m_run && m_pos == 1) ? 1 : 0);
        chk("pcd", pcd, (m_run && m_pos == 2) ? 1 : 0);
        chk("wrdec", wrdec, (m_run && m_pos == 3) ? 32'h80000 : 0);
        chk("exec_start", exec_start, (m_run && m_pos == 4 && op != 4'hF) ? 1 : 0);
        chk("busy", busy, m_run);
        chk("halted", halted, m_halt);
        chk("fault", fault, m_fault);
        chk("count", cnt, m_cnt);
    endtask

    task automatic tick(input bit s, input bit st, input logic [3:0] o, input bit d);
        @(negedge clk);
        start = s; stop_req = st; op = o; done = d;
        #1;
        check_model();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_state", state_out, 0);
        chk("rst_mem_ctrl", mem_ctrl, 0);
        chk("rst_pcd", pcd, 0);
        chk("rst_wrdec", wrdec, 0);
        chk("rst_exec_start", exec_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_count", cnt, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        start = 0; stop_req = 0; done = 0;
        model_reset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        async_reset();
    endtask

    typedef struct {
        bit         s, st, d;
        logic [3:0] o;
        int         e_state, e_mem, e_pcd, e_wr, e_es, e_busy, e_halt, e_cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int g;
        int r;
        bit stopped;
        bit sv;
        bit dv;

        //            s  st d  op    state mem pcd wr es busy halt cnt
        tbl[0]  = '{1, 0, 0, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 4'h2, 1, 1, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 4'h2, 2, 0, 1, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 4'h2, 3, 0, 0, 1, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 4'h2, 4, 0, 0, 0, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 1, 4'h2, 5, 0, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 4'h2, 1, 1, 0, 0, 0, 1, 0, 1};
        tbl[7]  = '{0, 0, 1, 4'h2, 2, 0, 1, 0, 0, 1, 0, 1};
        tbl[8]  = '{0, 1, 0, 4'h2, 3, 0, 0, 1, 0, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 4'h7, 4, 0, 0, 0, 1, 1, 0, 1};
        tbl[10] = '{0, 0, 0, 4'h7, 5, 0, 0, 0, 0, 1, 0, 1};
        tbl[11] = '{0, 0, 1, 4'h7, 5, 0, 0, 0, 0, 1, 0, 1};
        tbl[12] = '{1, 0, 0, 4'h7, 0, 0, 0, 0, 0, 0, 0, 2};
        tbl[13] = '{1, 1, 0, 4'h7, 1, 1, 0, 0, 0, 1, 0, 2};
        tbl[14] = '{0, 0, 0, 4'h7, 2, 0, 1, 0, 0, 1, 0, 2};

        model_reset();
        do_reset();

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            start = tbl[i].s; stop_req = tbl[i].st; op = tbl[i].o; done = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d_state", i), state_out, tbl[i].e_state);
            chk($sformatf("tbl%0d_mem", i), mem_ctrl, tbl[i].e_mem);
            chk($sformatf("tbl%0d_pcd", i), pcd, tbl[i].e_pcd);
            chk($sformatf("tbl%0d_wrdec", i), wrdec, tbl[i].e_wr ? 32'h80000 : 0);
            chk($sformatf("tbl%0d_exec_start", i), exec_start, tbl[i].e_es);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_halted", i), halted, tbl[i].e_halt);
            chk($sformatf("tbl%0d_count", i), cnt, tbl[i].e_cnt);
        end
        @(posedge clk);
        #1;

        // Reset while sitting in IR_LD, then a clean restart.
        chk("irld_state", state_out, 3);
        chk("irld_count", cnt, 2);
        async_reset();
        tick(1, 0, 4'h2, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 4'h2, 0);

        // Continuous fetch, stop pulsed during the third MIDR_LD.
        do_reset();
        g = 0; stopped = 0;
        while (!(m_cnt == 3 && !m_run) && g < 100) begin
            sv = m_run && m_pos == 2 && m_cnt == 2 && !stopped;
            if (sv) stopped = 1;
            tick(!stopped, sv, 4'h2, m_run && m_pos == 5);
            g++;
        end
        chk("stop_budget", (g < 100) ? 1 : 0, 1);
        chk("stop_state", state_out, 0);
        chk("stop_busy", busy, 0);
        chk("stop_count", cnt, 3);

        // Halt opcode: absorbing until reset.
        do_reset();
        tick(1, 0, 4'hF, 0);
        g = 0;
        while (!m_halt && g < 20) begin
            tick(0, 0, 4'hF, 0);
            g++;
        end
        chk("halt_state", state_out, 6);
        chk("halt_halted", halted, 1);
        chk("halt_count", cnt, 0);
        for (int i = 0; i < 10; i++) tick(i[0], 0, 4'h2, 0);
        chk("halt_sticky", state_out, 6);

        // Watchdog expiry with no completion.
        do_reset();
        tick(1, 0, 4'h2, 0);
        g = 0;
        while (!(m_run && m_pos == 5) && g < 20) begin
            tick(0, 0, 4'h2, 0);
            g++;
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 4'h2, 0);
        chk("wd3_state", state_out, 5);
        chk("wd3_fault", fault, 0);
        tick(0, 0, 4'h2, 0);
        chk("wd4_state", state_out, 6);
        chk("wd4_fault", fault, 1);
        chk("wd4_halted", halted, 1);

        // Completion in the timeout cycle wins.
        do_reset();
        tick(1, 0, 4'h2, 0);
        g = 0;
        while (!(m_run && m_pos == 5) && g < 20) begin
            tick(0, 0, 4'h2, 0);
            g++;
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 4'h2, 0);
        tick(0, 0, 4'h2, 1);
        chk("wdd_state", state_out, 1);
        chk("wdd_fault", fault, 0);
        chk("wdd_count", cnt, 1);

        // Counter wrap after 16 retirements.
        do_reset();
        g = 0; r = 0;
        while (r < 16 && g < 200) begin
            dv = m_run && m_pos == 5;
            tick(1, 0, 4'h3, dv);
            if (dv) r++;
            g++;
        end
        chk("wrap_count", cnt, 0);
        chk("wrap_state", state_out, 1);
        chk("wrap_busy", busy, 1);
        for (int i = 0; i < 5; i++) tick(1, 0, 4'h3, m_run && m_pos == 5);
        chk("wrap_next", cnt, 1);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 250 == 0) begin
                do_reset();
            end else begin
                tick(($urandom % 4) != 0,
                     ($urandom % 16) == 0,
                     (($urandom % 40) == 0) ? 4'hF : 4'($urandom % 15),
                     (m_run && m_pos == 5) ? (($urandom % 2) == 0) : (($urandom % 8) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Per-core control FSM that drives the fetch cycle in this order: instruction-memory read, MIDR latch with PC increment, IR write.
- After the fetch it hands the decoded opcode to the execute stage and waits for completion.
- Its outputs drive the memory Control port, PC pcd, and the fetch bits of WRDec_out. It also provides start/stop, halt detection, an execute watchdog and a retired-instruction counter.

Parameters:
- HALT_OPCODE, 4'b1111, IR opcode that stops the core.
- IR_WR_BIT, 19, bit of WRDec_out that writes IR.
- EXEC_TIMEOUT, 64, max cycles in EXEC before fault; 0 disables the watchdog.
- CNT_W, 16, width of instr_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; begin fetching from IDLE.
- stop_req  in  1  level; stop after the current instruction retires.
- ir_opcode  in  4  IR_out from IR.
- exec_done  in  1  1-cycle pulse from the execute stage.
- mem_ctrl  out  2  instruction-memory Control (2'b01 = read).
- pcd  out  1  PC increment strobe.
- wrdec_out  out  20  fetch write-decode; only IR_WR_BIT is ever driven.
- exec_start  out  1  1-cycle pulse: opcode valid, begin execute.
- busy  out  1  high in any state except IDLE and HALTED.
- halted  out  1  high in HALTED.
- fault  out  1  sticky watchdog fault.
- instr_count  out  CNT_W  retired-instruction count.
- state_out  out  3  current state encoding.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - mem_ctrl=2'b00, pcd=0, wrdec_out=0, exec_start=0.
  - busy=0, halted=0, fault=0, instr_count=0.
  - stop latch=0, watchdog=0.
  - Reset mid-fetch or mid-exec aborts without a retire count.
- All control outputs are Moore-decoded from the state register. They change only on clock edges and are 0 in any state not listed below.
- State encoding: IDLE=0, MEM_RD=1, MIDR_LD=2, IR_LD=3, DISPATCH=4, EXEC=5, HALTED=6. Code 7 is illegal and recovers to IDLE next cycle.
- Transitions:
  - IDLE: start=1 and stop_req=0 -> MEM_RD. If start and stop_req are both 1, stay in IDLE (stop has priority).
  - MEM_RD: mem_ctrl=2'b01 -> MIDR_LD.
  - MIDR_LD: pcd=1 -> IR_LD.
  - IR_LD: wrdec_out[IR_WR_BIT]=1 -> DISPATCH.
  - DISPATCH: ir_opcode==HALT_OPCODE -> HALTED, with no exec_start and no count. Otherwise exec_start=1 -> EXEC, watchdog cleared.
  - EXEC: exec_done=1 -> instr_count+1, then IDLE if the stop latch is set, else MEM_RD.
  - EXEC watchdog: increments each cycle without exec_done. When it reaches EXEC_TIMEOUT -> HALTED, fault=1. If exec_done arrives in the timeout cycle, done wins and there is no fault.
  - HALTED: absorbing; exited only by reset.
- Fetch latency: 3 cycles (MEM_RD, MIDR_LD, IR_LD); exec_start comes in the 4th cycle after leaving IDLE.
- With a 1-cycle execute, one instruction retires every 5 cycles.
- Stop latch:
  - Set when stop_req=1 in any busy state.
  - Cleared on entry to IDLE.
  - A stop never truncates a fetch or exec in progress.
- exec_done outside EXEC is ignored.
- instr_count wraps from all-ones to 0 with no flag.
- start held high is legal and produces continuous fetching.

Test Plan:
- Reset then start=1 for 1 cycle, opcode=4'b0010, exec_done one cycle after exec_start:
  - mem_ctrl=01 in cycle 1, pcd=1 in cycle 2, wrdec_out=20'h80000 in cycle 3, exec_start in cycle 4.
  - instr_count=1; the next MEM_RD follows immediately.
- start held, 3 instructions, then stop_req pulsed during the 3rd MIDR_LD:
  - 3rd instruction completes, instr_count=3, FSM in IDLE, busy=0.
- Opcode 4'b1111 at DISPATCH:
  - no exec_start, halted=1, instr_count unchanged.
  - start toggling has no effect until reset.
- EXEC_TIMEOUT=4, exec_done never asserted:
  - HALTED with fault=1 exactly 4 cycles after exec_start.
  - Repeat with exec_done on the 4th cycle: no fault, count+1.
- Assert reset during IR_LD:
  - all outputs 0 asynchronously, state_out=0, instr_count=0.
  - start afterwards restarts a clean fetch.
- CNT_W=4, 16 retired instructions:
  - instr_count wraps 15->0 and fetching continues.
